// File: rtl/uart_program_loader.sv
// Boot loader: pulls bytes from the UART RX FIFO, assembles little-endian words,
// and writes a length-prefixed program to memory. Optional checksum: UART_LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_data,
  output logic              busy,
  output logic              done,
  output logic              len_err
`ifdef UART_LOADER_CHECKSUM_EN
  ,
  output logic              csum_err
`endif
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'(64'd1 << ADDR_W);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_TAIL = ST_CSUM;
`else
  localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

  logic [2:0]       state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic             w_valid_q, w_valid_d;
  logic [31:0]      w_data_q, w_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
  logic             csum_err_q, csum_err_d;
`endif

  logic             pop_state;
  logic             byte_last;
  logic [31:0]      word_next;
  logic [CNT_W-1:0] addr_inc;

  // States in which the head byte is consumed.
  always_comb begin
    pop_state = (state_q == ST_LEN) | ((state_q == ST_DATA) & ~w_valid_q);
`ifdef UART_LOADER_CHECKSUM_EN
    pop_state = pop_state | (state_q == ST_CSUM);
`endif
  end

  assign fifo_rd_en = ~fifo_empty & pop_state;
  assign byte_last  = fifo_rd_en & (byte_idx_q == 2'd3);
  // New bytes enter at the top so the first byte ends up as the LSB.
  assign word_next  = {fifo_dout, shreg_q};
  assign addr_inc   = addr_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    len_d      = len_q;
    addr_d     = addr_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    len_err_d  = len_err_q;
`ifdef UART_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    csum_err_d = csum_err_q;
`endif

    if (fifo_rd_en) begin
      shreg_d    = word_next[31:8];
      byte_idx_d = byte_idx_q + 2'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LEN;
          byte_idx_d = 2'd0;
          shreg_d    = 24'd0;
          len_d      = '0;
          addr_d     = '0;
          len_err_d  = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d      = 32'd0;
          csum_err_d = 1'b0;
`endif
        end
      end
      ST_LEN: begin
        if (byte_last) begin
          if (word_next == 32'd0) begin
            state_d = ST_TAIL;
          end else if (word_next > MAX_LEN) begin
            len_err_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            len_d   = word_next[CNT_W-1:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_last) begin
          w_valid_d = 1'b1;
          w_data_d  = word_next;
        end else if (w_valid_q && w_ready) begin
          w_valid_d = 1'b0;
          addr_d    = addr_inc;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d     = sum_q + w_data_q;
`endif
          if (addr_inc == len_q) state_d = ST_TAIL;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_last) begin
          csum_err_d = (word_next != sum_q);
          state_d    = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LEN) | (state_d == ST_DATA);
`ifdef UART_LOADER_CHECKSUM_EN
    busy_d = busy_d | (state_d == ST_CSUM);
`endif
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= 2'd0;
      shreg_q    <= 24'd0;
      len_q      <= '0;
      addr_q     <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      csum_err_q <= csum_err_d;
`endif
    end
  end

  assign w_valid = w_valid_q;
  assign w_addr  = addr_q[ADDR_W-1:0];
  assign w_data  = w_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign len_err = len_err_q;
`ifdef UART_LOADER_CHECKSUM_EN
  assign csum_err = csum_err_q;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: byte-queue FIFO model, expected
// writes queued as frames are pushed and checked on each memory handshake.
module tb_uart_program_loader;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          w_valid;
  logic          w_ready;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;
  logic          busy;
  logic          done;
  logic          len_err;
`ifdef UART_LOADER_CHECKSUM_EN
  logic          csum_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]         fq[$];
  logic [AW+31:0]     sb[$];
  bit                 saw_valid;

  uart_program_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err)
`ifdef UART_LOADER_CHECKSUM_EN
    ,
    .csum_err   (csum_err)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: pop on the edge, present the new head shortly after.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
  end

  always @(posedge clk) begin
    #1;
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // Write monitor: every handshake is compared with the scoreboard head.
  always @(negedge clk) begin
    logic [AW+31:0] exp;
    if (w_valid) saw_valid = 1'b1;
    if (rstn && w_valid && w_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", w_addr, w_data);
      end else begin
        exp = sb.pop_front();
        if ({w_addr, w_data} !== exp) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   w_addr, w_data, exp[AW+31:32], exp[31:0]);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) fq.push_back(w[8*i +: 8]);
  endtask

  // Pushes count, n words (max 2) and, with checksum, the trailing sum.
  task automatic push_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input bit bad_c);
    logic [31:0] s;
    s = 32'd0;
    push_word(32'(n));
    if (n > 0) begin push_word(w0); sb.push_back({AW'(0), w0}); s = s + w0; end
    if (n > 1) begin push_word(w1); sb.push_back({AW'(1), w1}); s = s + w1; end
`ifdef UART_LOADER_CHECKSUM_EN
    push_word(bad_c ? ~s : s);
`else
    if (bad_c) s = 32'd0;
`endif
  endtask

  task automatic do_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles, required done=1", name, budget);
    end
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: got %0d writes outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; w_ready = 1'b1;
    fifo_empty = 1'b1; fifo_dout = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({w_valid, busy, done, len_err, fifo_rd_en, w_addr, w_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b le=%b rd=%b a=%0d dat=%h, required all 0",
               w_valid, busy, done, len_err, fifo_rd_en, w_addr, w_data);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    checks++;
    if (csum_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_csum_err: got %b, required 0", csum_err);
    end
`endif
    @(posedge clk); #2 rstn = 1'b1;
  endtask

  task automatic test_basic();
    push_frame(2, 32'hDEADBEEF, 32'h12345678, 1'b0);
    do_start();
    wait_done("basic", 300);
    wait_sb_empty("basic", 5);
    checks++;
    if ({done, len_err, busy} !== 3'b100 || fq.size() != 0) begin
      errors++;
      $display("FAIL basic_status: got done=%b len_err=%b busy=%b fifo=%0d, required 1 0 0 0",
               done, len_err, busy, fq.size());
    end
  endtask

  task automatic test_stall();
    int n;
    @(posedge clk); #2 w_ready = 1'b0;
    push_frame(2, 32'hDEADBEEF, 32'h12345678, 1'b0);
    do_start();
    n = 0;
    while (!w_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({w_valid, fifo_rd_en, w_addr, w_data} !== {1'b1, 1'b0, AW'(0), 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b rd=%b a=%0d d=%h, required v=1 rd=0 a=0 d=deadbeef",
                 w_valid, fifo_rd_en, w_addr, w_data);
      end
      @(negedge clk);
    end
    @(posedge clk); #2 w_ready = 1'b1;
    wait_done("stall", 300);
    wait_sb_empty("stall", 5);
  endtask

  task automatic test_max_len();
    push_word(32'h0000_4000);
    push_word(32'h0102_0304); sb.push_back({AW'(0), 32'h0102_0304});
    push_word(32'hA5A5_5A5A); sb.push_back({AW'(1), 32'hA5A5_5A5A});
    do_start();
    wait_sb_empty("max_len", 200);
    repeat (3) @(negedge clk);
    checks++;
    if ({len_err, done, busy} !== 3'b001) begin
      errors++;
      $display("FAIL max_len_status: got len_err=%b done=%b busy=%b, required 0 0 1",
               len_err, done, busy);
    end
    // A start while loading must not restart the frame.
    do_start();
    push_word(32'h7777_0001); sb.push_back({AW'(2), 32'h7777_0001});
    wait_sb_empty("start_ignored", 100);
    @(posedge clk); #2 rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL max_len_reset: got v=%b busy=%b done=%b, required 0 0 0", w_valid, busy, done);
    end
    @(posedge clk); #2 rstn = 1'b1;
  endtask

  task automatic test_len_err();
    push_word(32'h0000_4001);
    fq.push_back(8'h11); fq.push_back(8'h22);
    saw_valid = 1'b0;
    do_start();
    wait_done("len_err", 100);
    repeat (3) @(negedge clk);
    checks++;
    if ({len_err, done, saw_valid} !== 3'b110 || fq.size() != 2) begin
      errors++;
      $display("FAIL len_err_status: got len_err=%b done=%b saw_valid=%b fifo=%0d, required 1 1 0 2",
               len_err, done, saw_valid, fq.size());
    end
    fq.delete();
    @(negedge clk);
  endtask

  task automatic test_zero();
    int n;
    push_frame(0, 32'd0, 32'd0, 1'b0);
    do_start();
    n = 0;
    while (fq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if ({done, len_err, busy} !== 3'b100) begin
      errors++;
      $display("FAIL zero_done: got done=%b len_err=%b busy=%b after last byte, required 1 0 0",
               done, len_err, busy);
    end
    push_frame(1, 32'hCAFEF00D, 32'd0, 1'b0);
    do_start();
    wait_done("reload", 200);
    wait_sb_empty("reload", 5);
  endtask

  task automatic test_reset_mid();
    push_word(32'd2);
    push_word(32'h1111_2222); sb.push_back({AW'(0), 32'h1111_2222});
    fq.push_back(8'hAB); fq.push_back(8'hCD);
    do_start();
    wait_sb_empty("reset_mid_w0", 100);
    repeat (5) @(negedge clk);
    @(posedge clk); #2 rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_valid, busy, done, fq.size() == 0} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid: got v=%b busy=%b done=%b fifo=%0d, required 0 0 0 0",
               w_valid, busy, done, fq.size());
    end
    @(posedge clk); #2 rstn = 1'b1;
    push_frame(2, 32'h0BAD_CAFE, 32'h5555_AAAA, 1'b0);
    do_start();
    wait_done("reset_mid_reload", 300);
    wait_sb_empty("reset_mid_reload", 5);
  endtask

`ifdef UART_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    push_frame(2, 32'hDEADBEEF, 32'h12345678, 1'b0);
    do_start();
    wait_done("csum_good", 300);
    checks++;
    if (csum_err !== 1'b0) begin
      errors++;
      $display("FAIL csum_good: got csum_err=%b, required 0", csum_err);
    end
    push_word(32'd2);
    push_word(32'hDEADBEEF); sb.push_back({AW'(0), 32'hDEADBEEF});
    push_word(32'h12345678); sb.push_back({AW'(1), 32'h12345678});
    push_word(32'h0000_0000);
    do_start();
    wait_done("csum_bad", 300);
    checks++;
    if (csum_err !== 1'b1) begin
      errors++;
      $display("FAIL csum_bad: got csum_err=%b, required 1", csum_err);
    end
    wait_sb_empty("csum_bad", 5);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_max_len();
    test_len_err();
    test_zero();
    test_reset_mid();
`ifdef UART_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
